// File: rtl/vector_data_mem_if.sv
// vector_data_mem_if: M-stage lane bus plus host load/dump streaming port
// for vector_data_mem. master = core/host side, slave = memory.
interface vector_data_mem_if #(
   parameter int DATA_W = 18,
   parameter int ADDR_W = 10
);
   logic [ADDR_W-1:0]         a1m;
   logic [ADDR_W-1:0]         a2m;
   logic [ADDR_W-1:0]         a3m;
   logic [2:0][DATA_W-1:0]    write_data_m;
   logic                      mem_write_m;
   logic [2:0][DATA_W-1:0]    rdm;
   logic                      halt_core;
   logic                      stall_core;
   logic [1:0]                host_cmd;
   logic                      host_cmd_val;
   logic [ADDR_W:0]           host_len;
   logic [DATA_W-1:0]         host_wdata;
   logic                      host_wvalid;
   logic                      host_wready;
   logic [DATA_W-1:0]         host_rdata;
   logic                      host_rvalid;
   logic                      host_rready;
   logic                      done;
   logic                      addr_err;

   modport master (
      output a1m, a2m, a3m, write_data_m, mem_write_m, halt_core,
             host_cmd, host_cmd_val, host_len, host_wdata, host_wvalid, host_rready,
      input  rdm, stall_core, host_wready, host_rdata, host_rvalid, done, addr_err
   );

   modport slave (
      input  a1m, a2m, a3m, write_data_m, mem_write_m, halt_core,
             host_cmd, host_cmd_val, host_len, host_wdata, host_wvalid, host_rready,
      output rdm, stall_core, host_wready, host_rdata, host_rvalid, done, addr_err
   );
endinterface

// File: rtl/vector_data_mem.sv
// vector_data_mem: three-lane data memory for the filter-GPU M stage with a
// host streaming port for loading an image before a run and dumping it after.
// The core is stalled whenever the host side (IDLE/LOAD/DUMP) owns the array.
// Optional macro MEM_WRAP_CHECK_EN: in RUN, lanes whose address wrapped read 0,
// have their store suppressed, and set the sticky addr_err flag.
module vector_data_mem #(
   parameter int DATA_W = 18,
   parameter int ADDR_W = 10
) (
   input logic              clk,
   input logic              rst,
   vector_data_mem_if.slave bus
);
   localparam int DEPTH = 2**ADDR_W;
   localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;
   localparam logic [1:0] CMD_LOAD = 2'b01;
   localparam logic [1:0] CMD_DUMP = 2'b10;
   localparam logic [1:0] CMD_RUN  = 2'b11;

   typedef enum logic [1:0] {IDLE, LOAD, DUMP, RUN} state_t;

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  ptr_q;
   logic [ADDR_W-1:0]  ptr_inc;
   logic [ADDR_W:0]    cnt_q;
   logic [DATA_W-1:0]  rdata_q;
   logic               done_q;
   logic [DATA_W-1:0]  mem [DEPTH];

   logic cmd_load, cmd_dump, len_zero, load_acc, dump_acc, last, run_wr;
   logic wrap_l1, wrap_l2;

   assign len_zero = (bus.host_len == '0);
   assign cmd_load = (state_q == IDLE) && bus.host_cmd_val && (bus.host_cmd == CMD_LOAD);
   assign cmd_dump = (state_q == IDLE) && bus.host_cmd_val && (bus.host_cmd == CMD_DUMP);
   assign load_acc = (state_q == LOAD) && bus.host_wvalid;
   assign dump_acc = (state_q == DUMP) && bus.host_rready;
   assign last     = (cnt_q == CNT_ONE);
   assign run_wr   = (state_q == RUN) && bus.mem_write_m;
   assign ptr_inc  = ptr_q + 1'b1;

`ifdef MEM_WRAP_CHECK_EN
   logic addr_err_q;

   // lane1 wraps past the top, lane2 wraps below zero
   assign wrap_l1 = (state_q == RUN) && (bus.a1m == '1);
   assign wrap_l2 = (state_q == RUN) && (bus.a1m == '0);

   // sticky wrap flag, cleared only by reset or an accepted LOAD command
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         addr_err_q <= 1'b0;
      else if (cmd_load)
         addr_err_q <= 1'b0;
      else if (wrap_l1 || wrap_l2)
         addr_err_q <= 1'b1;
   end

   assign bus.addr_err = addr_err_q;
`else
   assign wrap_l1      = 1'b0;
   assign wrap_l2      = 1'b0;
   assign bus.addr_err = 1'b0;
`endif

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // next-state: commands only in IDLE, zero-length transfers never leave IDLE
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (bus.host_cmd_val) begin
               case (bus.host_cmd)
                  CMD_LOAD: if (!len_zero) state_d = LOAD;
                  CMD_DUMP: if (!len_zero) state_d = DUMP;
                  CMD_RUN:  state_d = RUN;
                  default:  state_d = IDLE;
               endcase
            end
         end
         LOAD:    if (load_acc && last) state_d = IDLE;
         DUMP:    if (dump_acc && last) state_d = IDLE;
         RUN:     if (bus.halt_core)    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // state-decoded outputs
   always_comb begin
      bus.stall_core  = (state_q != RUN);
      bus.host_wready = (state_q == LOAD);
      bus.host_rvalid = (state_q == DUMP);
   end

   // transfer pointer/count, prefetched dump word and completion pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q   <= '0;
         cnt_q   <= '0;
         rdata_q <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (cmd_load || cmd_dump) begin
            ptr_q <= '0;
            cnt_q <= bus.host_len;
            if (len_zero)
               done_q <= 1'b1;
            else if (cmd_dump)
               rdata_q <= mem[ADDR_ZERO];
         end else if (load_acc || dump_acc) begin
            ptr_q <= ptr_inc;
            cnt_q <= cnt_q - 1'b1;
            if (last)
               done_q <= 1'b1;
            else if (dump_acc)
               rdata_q <= mem[ptr_inc];
         end else if ((state_q == RUN) && bus.halt_core) begin
            done_q <= 1'b1;
         end
      end
   end

   // array writes: host LOAD stream or the three core lanes in RUN (no reset)
   always_ff @(posedge clk) begin
      if (load_acc)
         mem[ptr_q] <= bus.host_wdata;
      if (run_wr) begin
         mem[bus.a1m] <= bus.write_data_m[0];
         if (!wrap_l1) mem[bus.a2m] <= bus.write_data_m[1];
         if (!wrap_l2) mem[bus.a3m] <= bus.write_data_m[2];
      end
   end

   // zero-latency lane reads; a write at the same edge is seen next cycle
   always_comb begin
      bus.rdm[0] = mem[bus.a1m];
      bus.rdm[1] = wrap_l1 ? '0 : mem[bus.a2m];
      bus.rdm[2] = wrap_l2 ? '0 : mem[bus.a3m];
   end

   assign bus.host_rdata = rdata_q;
   assign bus.done       = done_q;
endmodule
